// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: frames 11-bit serial bytes, strips E0/F0 prefixes and emits one-cycle make-code pulses.
// Define TYPEMATIC_FILTER_EN to suppress auto-repeat makes of the key currently held down.
module ps2_keycode_rx #(
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] key_code_o,
   output logic       key_valid_o,
   output logic       extended_o,
   output logic       frame_err_o
);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} fstate_e;
   typedef enum logic [1:0] {D_NORMAL, D_E0, D_F0, D_E0F0} dstate_e;

   logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
   logic                   clk_prev_q;
   logic                   fall, din;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         clk_prev_q  <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
         clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
      end
   end

   assign fall = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
   assign din  = data_sync_q[SYNC_STAGES-1];

   fstate_e         fstate_q, fstate_d;
   logic [7:0]      shift_q, shift_d, byte_q, byte_d;
   logic [2:0]      bitcnt_q, bitcnt_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            par_q, par_d, stop_q, stop_d;
   logic            chk_q, chk_d, byte_vld_q, byte_vld_d, err_q, err_d;

   always_comb begin
      fstate_d   = fstate_q;
      shift_d    = shift_q;
      byte_d     = byte_q;
      bitcnt_d   = bitcnt_q;
      par_d      = par_q;
      stop_d     = stop_q;
      tmo_d      = '0;
      chk_d      = 1'b0;
      byte_vld_d = 1'b0;
      err_d      = 1'b0;
      // Frame check runs the cycle after the stop edge; shift_q is still stable here.
      if (chk_q) begin
         if (stop_q && (^{shift_q, par_q})) begin
            byte_vld_d = 1'b1;
            byte_d     = shift_q;
         end else begin
            err_d = 1'b1;
         end
      end
      case (fstate_q)
         F_IDLE:   if (fall && !din) begin
                      fstate_d = F_DATA;
                      bitcnt_d = '0;
                   end
         F_DATA:   if (fall) begin
                      shift_d  = {din, shift_q[7:1]};
                      bitcnt_d = bitcnt_q + 3'd1;
                      if (bitcnt_q == 3'd7) fstate_d = F_PARITY;
                   end
         F_PARITY: if (fall) begin
                      par_d    = din;
                      fstate_d = F_STOP;
                   end
         F_STOP:   if (fall) begin
                      stop_d   = din;
                      chk_d    = 1'b1;
                      fstate_d = F_IDLE;
                   end
         default:  fstate_d = F_IDLE;
      endcase
      // An edge in the terminal-count cycle wins: tmo_d stays cleared, no error.
      if (fstate_q != F_IDLE && !fall) begin
         if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            err_d    = 1'b1;
            fstate_d = F_IDLE;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fstate_q   <= F_IDLE;
         shift_q    <= '0;
         byte_q     <= '0;
         bitcnt_q   <= '0;
         par_q      <= 1'b0;
         stop_q     <= 1'b0;
         tmo_q      <= '0;
         chk_q      <= 1'b0;
         byte_vld_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         fstate_q   <= fstate_d;
         shift_q    <= shift_d;
         byte_q     <= byte_d;
         bitcnt_q   <= bitcnt_d;
         par_q      <= par_d;
         stop_q     <= stop_d;
         tmo_q      <= tmo_d;
         chk_q      <= chk_d;
         byte_vld_q <= byte_vld_d;
         err_q      <= err_d;
      end
   end

   dstate_e    dstate_q, dstate_d;
   logic [7:0] code_q, code_d;
   logic       valid_q, valid_d, ext_q, ext_d;
   logic       emit, emit_ext, nonkey;

   assign nonkey = byte_q inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

`ifdef TYPEMATIC_FILTER_EN
   logic [8:0] held_q, held_d;
   logic       brk, brk_ext;

   assign brk     = byte_vld_q && !err_q &&
                    ((dstate_q == D_F0 && byte_q != 8'hE0) || dstate_q == D_E0F0);
   assign brk_ext = (dstate_q == D_E0F0);
`endif

   always_comb begin
      dstate_d = dstate_q;
      emit     = 1'b0;
      emit_ext = 1'b0;
      valid_d  = 1'b0;
      code_d   = 8'h00;
      ext_d    = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
      held_d   = held_q;
      if (brk && {brk_ext, byte_q} == held_q) held_d = '0;
`endif
      if (err_q) begin
         dstate_d = D_NORMAL;
      end else if (byte_vld_q) begin
         case (dstate_q)
            D_NORMAL: if (byte_q == 8'hE0)      dstate_d = D_E0;
                      else if (byte_q == 8'hF0) dstate_d = D_F0;
                      else if (!nonkey)         emit = 1'b1;
            D_E0:     if (byte_q == 8'hF0)      dstate_d = D_E0F0;
                      else if (byte_q != 8'hE0) begin
                         emit     = 1'b1;
                         emit_ext = 1'b1;
                         dstate_d = D_NORMAL;
                      end
            D_F0:     dstate_d = (byte_q == 8'hE0) ? D_E0 : D_NORMAL;
            default:  dstate_d = D_NORMAL;
         endcase
      end
`ifdef TYPEMATIC_FILTER_EN
      if (emit && {emit_ext, byte_q} != held_q) begin
         valid_d = 1'b1;
         held_d  = {emit_ext, byte_q};
      end
`else
      valid_d = emit;
`endif
      if (valid_d) begin
         code_d = byte_q;
         ext_d  = emit_ext;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dstate_q <= D_NORMAL;
         code_q   <= 8'h00;
         valid_q  <= 1'b0;
         ext_q    <= 1'b0;
`ifdef TYPEMATIC_FILTER_EN
         held_q   <= '0;
`endif
      end else begin
         dstate_q <= dstate_d;
         code_q   <= code_d;
         valid_q  <= valid_d;
         ext_q    <= ext_d;
`ifdef TYPEMATIC_FILTER_EN
         held_q   <= held_d;
`endif
      end
   end

   assign key_code_o  = code_q;
   assign key_valid_o = valid_q;
   assign extended_o  = ext_q;
   assign frame_err_o = err_q;
endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: table of PS/2 frames with a scoreboard of expected make codes, plus timeout and reset sequences.
module tb_ps2_keycode_rx;
   localparam int TMO = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] key_code;
   logic       key_valid, extended, frame_err;

   ps2_keycode_rx #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
      .key_code_o(key_code), .key_valid_o(key_valid), .extended_o(extended),
      .frame_err_o(frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;
   int err_seen = 0, err_exp = 0, idle_viol = 0;
   int last_fall = 0, last_valid_cyc = 0, err_cyc = 0;
   logic [8:0] exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Scoreboard: every key_valid pulse must match the oldest expected make code.
   always @(negedge clk) begin
      if (rst_n) begin
         if (key_valid) begin
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) chk("unexpected key_valid", {23'd0, extended, key_code}, 32'h1ff);
            else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               chk("key_code", key_code, e[7:0]);
               chk("extended", extended, e[8]);
            end
         end else if (key_code !== 8'h00 || extended !== 1'b0) idle_viol++;
         if (frame_err) begin
            err_seen++;
            err_cyc = cyc;
         end
      end
   end

   function automatic logic [10:0] frame(input logic [7:0] b, input bit par_ok);
      logic p;
      p = ~(^b);
      if (!par_ok) p = ~p;
      return {1'b1, p, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] fr, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1 ps2_data = fr[i];
         repeat (4) @(posedge clk);
         #1 ps2_clk = 1'b0;
         last_fall = cyc;
         repeat (8) @(posedge clk);
         #1 ps2_clk = 1'b1;
         repeat (4) @(posedge clk);
      end
   endtask

   typedef struct {
      logic [7:0] b;
      bit         par_ok;
      bit         exp_v;
      bit         exp_ext;
   } vec_t;

`ifdef TYPEMATIC_FILTER_EN
   localparam bit REP = 1'b0;
`else
   localparam bit REP = 1'b1;
`endif

   vec_t vt[$];

   initial begin
      vt = '{
         '{8'h5A, 1, 1, 0},
         '{8'hE0, 1, 0, 0}, '{8'h75, 1, 1, 1},
         '{8'hE0, 1, 0, 0}, '{8'hF0, 1, 0, 0}, '{8'h75, 1, 0, 0},
         '{8'h2B, 0, 0, 0}, '{8'h2B, 1, 1, 0},
         '{8'hF0, 1, 0, 0}, '{8'h1C, 1, 0, 0}, '{8'hAA, 1, 0, 0},
         '{8'h72, 1, 1, 0},
         '{8'h74, 1, 1, 0}, '{8'h74, 1, REP, 0}, '{8'h74, 1, REP, 0},
         '{8'hF0, 1, 0, 0}, '{8'h74, 1, 0, 0},
         '{8'h74, 1, 1, 0}
      };

      repeat (3) @(posedge clk);
      #1;
      chk("reset key_code", key_code, 8'h00);
      chk("reset key_valid", key_valid, 1'b0);
      chk("reset extended", extended, 1'b0);
      chk("reset frame_err", frame_err, 1'b0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);

      foreach (vt[k]) begin
         if (vt[k].exp_v) exp_q.push_back({vt[k].exp_ext, vt[k].b});
         if (!vt[k].par_ok) err_exp++;
         send_bits(frame(vt[k].b, vt[k].par_ok), 11);
         repeat (10) @(posedge clk);
         chk($sformatf("pending after vec %0d", k), exp_q.size(), 0);
         chk($sformatf("frame_err count vec %0d", k), err_seen, err_exp);
         if (vt[k].exp_v) chk($sformatf("latency vec %0d", k), last_valid_cyc - last_fall, 5);
      end

      // Partial frame then idle ps2_clk: timeout error TMO cycles after the last detected edge.
      send_bits(frame(8'h6B, 1), 5);
      err_exp++;
      for (int i = 0; i < 400 && err_seen < err_exp; i++) @(posedge clk);
      chk("timeout frame_err", err_seen, err_exp);
      chk("timeout cycle", err_cyc - last_fall, TMO + 3);
      exp_q.push_back({1'b0, 8'h6B});
      send_bits(frame(8'h6B, 1), 11);
      repeat (10) @(posedge clk);
      chk("after timeout pending", exp_q.size(), 0);

      // Reset while key_valid is high clears outputs asynchronously.
      send_bits(frame(8'h29, 1), 10);
      @(posedge clk); #1 ps2_data = 1'b1;
      repeat (4) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("pre-reset key_valid", key_valid, 1'b1);
      chk("pre-reset key_code", key_code, 8'h29);
      rst_n = 1'b0;
      #1;
      chk("async reset key_valid", key_valid, 1'b0);
      chk("async reset key_code", key_code, 8'h00);
      ps2_clk = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset mid-frame: partial frame is lost, nothing emitted, no timeout afterwards.
      send_bits(frame(8'h15, 1), 4);
      rst_n = 1'b0;
      #1;
      chk("mid-frame reset frame_err", frame_err, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2 * TMO) @(posedge clk);
      chk("mid-frame reset no error", err_seen, err_exp);
      chk("mid-frame reset no key", exp_q.size(), 0);
      exp_q.push_back({1'b0, 8'h15});
      send_bits(frame(8'h15, 1), 11);
      repeat (10) @(posedge clk);

      chk("final pending", exp_q.size(), 0);
      chk("final frame_err count", err_seen, err_exp);
      chk("key_code idle zero", idle_viol, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ps2_keycode_rx.md
Name: ps2_keycode_rx

Overview:
- Receives PS/2 keyboard frames and decodes scan-code sequences into single-cycle make-code events.
- Its key_code output drives the game datapath's keyCode input directly.
- key_code rests at 8'h00; on each key press it shows the make code for exactly one clk, so level comparisons downstream fire once per press.
- Break sequences and E0 prefixes are consumed internally. Arrow keys therefore appear as bare 8'h75/72/74/6B.

Parameters:
- TIMEOUT_CYCLES, 50000: clk cycles without a ps2_clk falling edge, mid-frame, before the partial frame is dropped (1 ms at 50 MHz).
- SYNC_STAGES, 2: flip-flop stages synchronizing ps2_clk and ps2_data; minimum 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ps2_clk  input  1  raw PS/2 clock from keyboard (asynchronous)
- ps2_data  input  1  raw PS/2 data from keyboard (asynchronous)
- key_code  output  8  make code during the key_valid cycle, else 8'h00
- key_valid  output  1  one-cycle pulse marking a new key press
- extended  output  1  high with key_valid when the code was E0-prefixed
- frame_err  output  1  one-cycle pulse on parity, stop or timeout error

Behaviour:
- Reset (async assert, sync release):
  - key_code=8'h00; key_valid=0, extended=0, frame_err=0.
  - Frame FSM in IDLE; decoder in NORMAL; shift register, bit count and timeout counter cleared.
  - Synchronizers preset to 1.
- Sampling:
  - ps2_clk and ps2_data pass through SYNC_STAGES flip-flops.
  - A falling edge is synced_clk_prev=1 and synced_clk=0.
  - ps2_data is sampled only in the cycle a falling edge is detected.
- Frame FSM (11-bit frame: start 0, 8 data bits LSB first, odd parity, stop 1):
  - IDLE: on an edge with data=0, go to DATA with bit count 0. An edge with data=1 is a spurious start; stay in IDLE with no error.
  - DATA: shift data into bit [7] and shift right. After the 8th bit, go to PARITY.
  - PARITY: store the parity bit and go to STOP.
  - STOP: accept the frame if data=1 and XOR(byte, parity)=1; emit the byte to the decoder one cycle later. Otherwise pulse frame_err and discard the byte. Return to IDLE in both cases.
  - Timeout: in any state except IDLE, the counter increments each clk and clears on every edge. At TIMEOUT_CYCLES it pulses frame_err and returns to IDLE.
- Decoder FSM (runs on accepted bytes):
  - NORMAL: E0 -> GOT_E0; F0 -> GOT_F0; a non-key byte (00, AA, EE, FA, FE, FF) is dropped; any other byte is emitted as a make code with extended=0.
  - GOT_E0: F0 -> GOT_E0F0; E0 stays in GOT_E0; any other byte is emitted with extended=1, then NORMAL.
  - GOT_F0: any byte is a break and is consumed silently -> NORMAL. An E0 here -> GOT_E0.
  - GOT_E0F0: any byte is consumed silently -> NORMAL.
  - frame_err or timeout forces the decoder to NORMAL.
- Latency: key_valid rises 2 clk after the clk edge that detects the stop-bit falling edge (1 cycle frame check, 1 cycle decode register). key_code, key_valid and extended are registered and change together.
- Simultaneous events: an edge arriving in the same cycle the timeout count is reached wins; the counter clears and no error is raised.
- Reset mid-frame: the partial byte and prefix state are lost; no output is produced for that frame.
- The block never drives ps2_clk or ps2_data (receive-only).

Optional Feature:
- Macro TYPEMATIC_FILTER_EN.
- Defined:
  - The block holds a 9-bit held register {ext, code}, cleared at reset.
  - A make matching held is suppressed (no key_valid).
  - A non-matching make is emitted and loads held.
  - A break whose {ext, code} equals held clears held.
  - Holding an arrow key moves the cursor once only.
- Undefined: every typematic repeat make is emitted as a new key_valid pulse. No held register exists.

Test Plan:
- Frame 0x5A with parity 1 and stop 1 -> one pulse key_valid=1, key_code=8'h5A, extended=0; key_code=8'h00 in the surrounding cycles.
- Sequence E0 75, then E0 F0 75 -> exactly one pulse, key_code=8'h75 with extended=1. The break produces no pulse; the decoder ends in NORMAL.
- Frame 0x2B with parity 0 (wrong) -> frame_err pulse, no key_valid. A following good 0x2B -> key_valid with 8'h2B.
- Start bit, then 4 data bits, then ps2_clk idle for TIMEOUT_CYCLES (set to 100 in the bench) -> frame_err at cycle 100. A following full frame 0x6B decodes correctly.
- F0 1C, then AA -> no key_valid for either. Then 0x72 -> key_valid with 8'h72.
- Three 0x74 make frames, then F0 74, then 0x74:
  - TYPEMATIC_FILTER_EN defined -> 2 pulses.
  - Undefined -> 4 pulses.
  - Additionally, rst_n asserted mid-frame clears all outputs to reset values immediately (asynchronously).
